// File: rtl/dma_pkg.sv
// Shared defaults and FSM state encoding for the DMA block reader.
// Every file that needs the widths or the state type imports this package.
package dma_pkg;

   localparam int DMA_ADDR_WIDTH = 16;
   localparam int DMA_DATA_WIDTH = 16;
   localparam int DMA_KERNEL_DIM = 5;
   localparam int DMA_BLOCK_SIZE = DMA_KERNEL_DIM * DMA_KERNEL_DIM;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      READ       = 3'd1,
      READ_DRAIN = 3'd2,
      HOLD       = 3'd3,
      WRITE      = 3'd4,
      DONE       = 3'd5
   } dma_state_e;

   // Counter width for a range of n values; never returns zero.
   function automatic int dma_cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dma_block_reader_if.sv
// Command, block and memory-port bundle of the DMA block reader.
// The master modport is the reader itself; the slave modport is its environment.
interface dma_block_reader_if #(
   parameter int ADDR_WIDTH = dma_pkg::DMA_ADDR_WIDTH,
   parameter int DATA_WIDTH = dma_pkg::DMA_DATA_WIDTH,
   parameter int BLOCK_SIZE = dma_pkg::DMA_BLOCK_SIZE
);

   logic                             start;
   logic                             cmd_rw;
   logic [ADDR_WIDTH-1:0]            base_address;
   logic [ADDR_WIDTH-1:0]            row_pitch;
   logic [BLOCK_SIZE*DATA_WIDTH-1:0] block_in;
   logic                             cmd_ready;
   logic [BLOCK_SIZE*DATA_WIDTH-1:0] block_out;
   logic                             block_valid;
   logic                             block_ready;
   logic                             write_done;
   logic                             mem_enable;
   logic                             mem_rw;
   logic [ADDR_WIDTH-1:0]            mem_address;
   logic [DATA_WIDTH-1:0]            mem_wdata;
   logic [DATA_WIDTH-1:0]            mem_rdata;

   modport master (
      input  start, cmd_rw, base_address, row_pitch, block_in, block_ready, mem_rdata,
      output cmd_ready, block_out, block_valid, write_done,
             mem_enable, mem_rw, mem_address, mem_wdata
   );

   modport slave (
      output start, cmd_rw, base_address, row_pitch, block_in, block_ready, mem_rdata,
      input  cmd_ready, block_out, block_valid, write_done,
             mem_enable, mem_rw, mem_address, mem_wdata
   );

endinterface

// File: rtl/dma_addr_gen.sv
// Walks a KERNEL_DIM x KERNEL_DIM block in row-major order and produces word addresses.
// Row starts come from an accumulator stepped by row_pitch, so no multiplier is needed.
module dma_addr_gen
   import dma_pkg::*;
#(
   parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
   parameter int KERNEL_DIM = DMA_KERNEL_DIM
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [ADDR_WIDTH-1:0] base_address,
   input  logic [ADDR_WIDTH-1:0] row_pitch,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  last
);

   localparam int                  CW      = dma_cnt_width(KERNEL_DIM);
   localparam logic [CW-1:0]       IDX_MAX = CW'(KERNEL_DIM - 1);
   localparam logic [CW-1:0]       CNT_ONE = CW'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   logic [CW-1:0]         row_r;
   logic [CW-1:0]         col_r;
   logic [ADDR_WIDTH-1:0] row_base_r;
   logic [ADDR_WIDTH-1:0] pitch_r;
   logic [ADDR_WIDTH-1:0] addr_r;

   // Counter and accumulator update; the final step parks everything at zero so
   // the address bus idles low once the block has been walked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_r      <= '0;
         col_r      <= '0;
         row_base_r <= '0;
         pitch_r    <= '0;
         addr_r     <= '0;
      end else if (load) begin
         row_r      <= '0;
         col_r      <= '0;
         row_base_r <= base_address;
         pitch_r    <= row_pitch;
         addr_r     <= base_address;
      end else if (step) begin
         if (col_r == IDX_MAX) begin
            if (row_r == IDX_MAX) begin
               row_r      <= '0;
               col_r      <= '0;
               row_base_r <= '0;
               pitch_r    <= '0;
               addr_r     <= '0;
            end else begin
               row_r      <= row_r + CNT_ONE;
               col_r      <= '0;
               row_base_r <= row_base_r + pitch_r;
               addr_r     <= row_base_r + pitch_r;
            end
         end else begin
            col_r  <= col_r + CNT_ONE;
            addr_r <= addr_r + ADDR_ONE;
         end
      end else begin
         addr_r <= addr_r;
      end
   end

   assign address = addr_r;
   assign last    = (row_r == IDX_MAX) && (col_r == IDX_MAX);

endmodule

// File: rtl/dma_block_reader.sv
// Moves one KERNEL_DIM x KERNEL_DIM block of signed words between memory and a
// wide parallel port, fetching (cmd_rw=1) or storing (cmd_rw=0) one word per cycle.
module dma_block_reader
   import dma_pkg::*;
#(
   parameter int ADDR_WIDTH = DMA_ADDR_WIDTH,
   parameter int DATA_WIDTH = DMA_DATA_WIDTH,
   parameter int KERNEL_DIM = DMA_KERNEL_DIM
) (
   input logic                clk,
   input logic                rst,
   dma_block_reader_if.master bus
);

   localparam int BLOCK_SIZE = KERNEL_DIM * KERNEL_DIM;
   localparam int BLOCK_BITS = BLOCK_SIZE * DATA_WIDTH;

   dma_state_e            state_r;
   dma_state_e            state_s;
   logic                  gen_load_s;
   logic                  gen_step_s;
   logic                  gen_last_s;
   logic [ADDR_WIDTH-1:0] gen_addr_s;

   logic                  cmd_ready_r;
   logic                  mem_enable_r;
   logic                  mem_rw_r;
   logic                  block_valid_r;
   logic                  write_done_r;
   logic                  rd_pend_r;
   logic [DATA_WIDTH-1:0] mem_wdata_r;
   logic [BLOCK_BITS-1:0] block_out_r;
   logic [BLOCK_BITS-1:0] store_lat_r;

   dma_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .KERNEL_DIM (KERNEL_DIM)
   ) u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .load         (gen_load_s),
      .step         (gen_step_s),
      .base_address (bus.base_address),
      .row_pitch    (bus.row_pitch),
      .address      (gen_addr_s),
      .last         (gen_last_s)
   );

   // Next-state decode and address-generator control.
   always_comb begin
      state_s    = state_r;
      gen_load_s = 1'b0;
      gen_step_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               gen_load_s = 1'b1;
               if (bus.cmd_rw) begin
                  state_s = READ;
               end else begin
                  state_s = WRITE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            gen_step_s = 1'b1;
            if (gen_last_s) begin
               state_s = READ_DRAIN;
            end else begin
               state_s = READ;
            end
         end
         READ_DRAIN: begin
            state_s = HOLD;
         end
         HOLD: begin
            if (bus.block_ready) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         WRITE: begin
            gen_step_s = 1'b1;
            if (gen_last_s) begin
               state_s = DONE;
            end else begin
               state_s = WRITE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register; status and strobe outputs are registered from the next state
   // so they line up with the cycle the state is actually in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         cmd_ready_r   <= 1'b1;
         mem_enable_r  <= 1'b0;
         mem_rw_r      <= 1'b0;
         block_valid_r <= 1'b0;
         write_done_r  <= 1'b0;
      end else begin
         state_r       <= state_s;
         cmd_ready_r   <= (state_s == IDLE);
         mem_enable_r  <= (state_s == READ) || (state_s == WRITE);
         mem_rw_r      <= (state_s == READ);
         block_valid_r <= (state_s == HOLD);
         write_done_r  <= (state_s == DONE);
      end
   end

   // Datapath: read words shift in from the top so that after a full block element 0
   // sits at the bottom; store words shift out of a private copy of block_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend_r   <= 1'b0;
         block_out_r <= '0;
         store_lat_r <= '0;
         mem_wdata_r <= '0;
      end else begin
         rd_pend_r <= mem_enable_r & mem_rw_r;
         if (rd_pend_r) begin
            block_out_r <= {bus.mem_rdata, block_out_r[BLOCK_BITS-1:DATA_WIDTH]};
         end else begin
            block_out_r <= block_out_r;
         end
         if (gen_load_s && !bus.cmd_rw) begin
            mem_wdata_r <= bus.block_in[DATA_WIDTH-1:0];
            store_lat_r <= bus.block_in >> DATA_WIDTH;
         end else if (gen_step_s && (state_s == WRITE)) begin
            mem_wdata_r <= store_lat_r[DATA_WIDTH-1:0];
            store_lat_r <= store_lat_r >> DATA_WIDTH;
         end else begin
            mem_wdata_r <= '0;
         end
      end
   end

   assign bus.cmd_ready   = cmd_ready_r;
   assign bus.block_out   = block_out_r;
   assign bus.block_valid = block_valid_r;
   assign bus.write_done  = write_done_r;
   assign bus.mem_enable  = mem_enable_r;
   assign bus.mem_rw      = mem_rw_r;
   assign bus.mem_address = gen_addr_s;
   assign bus.mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_dma_block_reader.sv
// Randomized bench for dma_block_reader: a transaction-level model predicts every
// output each cycle; directed cases pin the model with hand-computed values.
module tb_dma_block_reader;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int KD = 5;
   localparam int BS = KD * KD;
   localparam int BW = BS * DW;

   localparam int P_IDLE = 0;
   localparam int P_XFER = 1;
   localparam int P_HOLD = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dma_block_reader_if bus ();

   dma_block_reader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] salt = 16'h0000;

   int            m_phase = P_IDLE;
   int            m_e     = 0;
   logic          m_rw    = 1'b0;
   logic [AW-1:0] m_base  = '0;
   logic [AW-1:0] m_pitch = '0;
   logic [DW-1:0] m_blk [BS];
   logic [BW-1:0] m_exp   = '0;

   function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic [AW-1:0] p, input int k);
      int t;
      t = int'(b) + (k / KD) * int'(p) + (k % KD);
      return t[AW-1:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory: word at address a holds a ^ salt; read data arrives one cycle later,
   // and anything else on the read bus is noise.
   always @(posedge clk) begin
      if (bus.mem_enable && bus.mem_rw) bus.mem_rdata <= bus.mem_address ^ salt;
      else bus.mem_rdata <= 16'($urandom);
   end

   // Transaction model: phase plus elapsed edges since the command was accepted.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = P_IDLE;
         m_e     = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (bus.start) begin
               m_rw    = bus.cmd_rw;
               m_base  = bus.base_address;
               m_pitch = bus.row_pitch;
               for (int k = 0; k < BS; k++) begin
                  m_blk[k] = bus.block_in[k*DW +: DW];
                  m_exp[k*DW +: DW] = addr_of(bus.base_address, bus.row_pitch, k) ^ salt;
               end
               m_e     = 0;
               m_phase = P_XFER;
            end
            P_XFER: begin
               m_e++;
               if (m_e == BS + 1) m_phase = m_rw ? P_HOLD : P_IDLE;
            end
            P_HOLD: if (bus.block_ready) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
         endcase
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (!rst) begin
         logic en;
         en = (m_phase == P_XFER) && (m_e < BS);
         check("cmd_ready",   bus.cmd_ready,   m_phase == P_IDLE);
         check("mem_enable",  bus.mem_enable,  en);
         check("mem_rw",      bus.mem_rw,      en && m_rw);
         check("mem_address", bus.mem_address, en ? addr_of(m_base, m_pitch, m_e) : 16'h0000);
         check("mem_wdata",   bus.mem_wdata,   (en && !m_rw) ? m_blk[m_e] : 16'h0000);
         check("write_done",  bus.write_done,  (m_phase == P_XFER) && (m_e == BS) && !m_rw);
         check("block_valid", bus.block_valid, m_phase == P_HOLD);
         if (m_phase == P_HOLD) check_vec("block_out", bus.block_out, m_exp);
      end
   end

   task automatic noise(input bit on);
      bus.start        = on ? 1'($urandom) : 1'b0;
      bus.cmd_rw       = 1'($urandom);
      bus.base_address = 16'($urandom);
      bus.row_pitch    = 16'($urandom);
   endtask

   // Called #1 after an edge with the reader idle; returns #1 after the accept edge.
   task automatic issue(input logic rw, input logic [AW-1:0] base, input logic [AW-1:0] pitch,
                        input logic [BW-1:0] blk);
      bus.start = 1'b1;
      bus.cmd_rw = rw;
      bus.base_address = base;
      bus.row_pitch = pitch;
      bus.block_in = blk;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < BS; k++) bus.block_in[k*DW +: DW] = 16'($urandom);
      bus.base_address = 16'($urandom);
      bus.row_pitch = 16'($urandom);
   endtask

   task automatic complete(input int hold, input bit on);
      int n;
      n = 0;
      while (m_phase == P_XFER && n < 40) begin
         noise(on);
         bus.block_ready = on ? 1'($urandom) : 1'b0;
         @(posedge clk); #1;
         n++;
      end
      bus.block_ready = 1'b0;
      if (m_phase == P_XFER) begin
         n_cmp++; n_bad++;
         $display("FAIL complete_timeout: transfer still running after %0d cycles", n);
      end
      if (m_phase == P_HOLD) begin
         for (int i = 0; i < hold; i++) begin
            noise(on);
            @(posedge clk); #1;
         end
         bus.start = 1'b0;
         bus.block_ready = 1'b1;
         @(posedge clk); #1;
         bus.block_ready = 1'b0;
      end
      bus.start = 1'b0;
   endtask

   logic [BW-1:0] blk;
   int            n;
   int            cnt_a;
   int            cnt_b;

   initial begin
      bus.start = 1'b0; bus.cmd_rw = 1'b0; bus.base_address = '0; bus.row_pitch = '0;
      bus.block_in = '0; bus.block_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_enable",  bus.mem_enable, 0);
      check("rst_mem_rw",      bus.mem_rw, 0);
      check("rst_mem_address", bus.mem_address, 0);
      check("rst_mem_wdata",   bus.mem_wdata, 0);
      check("rst_block_valid", bus.block_valid, 0);
      check("rst_write_done",  bus.write_done, 0);
      check_vec("rst_block_out", bus.block_out, '0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_cmd_ready", bus.cmd_ready, 1);

      // Fetch base 0, pitch 4, word i = i.
      salt = 16'h0000;
      issue(1'b1, 16'h0000, 16'h0004, '0);
      n = 0;
      while (!bus.block_valid && n < 40) begin @(posedge clk); #1; n++; end
      check("t1_valid_latency", n, 26);
      check("t1_elem4",  bus.block_out[4*DW +: DW], 16'd4);
      check("t1_elem5",  bus.block_out[5*DW +: DW], 16'd4);
      check("t1_elem6",  bus.block_out[6*DW +: DW], 16'd5);
      check("t1_elem24", bus.block_out[24*DW +: DW], 16'd20);
      complete(0, 1'b0);

      // Fetch held for 10 cycles with start pulses hammering the port.
      salt = 16'h5a5a;
      issue(1'b1, 16'h1234, 16'h0040, '0);
      repeat (26) @(posedge clk);
      #1;
      check("t2_elem0", bus.block_out[DW-1:0], 16'h486e);
      complete(10, 1'b1);

      // Store base 100, pitch 10, element k = 0x0400 + k; block_in scrambled after accept.
      for (int k = 0; k < BS; k++) blk[k*DW +: DW] = 16'h0400 + 16'(k);
      issue(1'b0, 16'd100, 16'd10, blk);
      check("t3_addr0", bus.mem_address, 16'd100);
      repeat (24) @(posedge clk);
      #1;
      check("t3_addr24",  bus.mem_address, 16'd144);
      check("t3_wdata24", bus.mem_wdata, 16'h0418);
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bus.write_done) begin
            cnt_a++;
            cnt_b = 25 + i;
         end
      end
      check("t3_done_count", cnt_a, 1);
      check("t3_done_edge",  cnt_b, 25);

      // Address wrap.
      salt = 16'h0000;
      issue(1'b1, 16'hfffe, 16'h0001, '0);
      repeat (26) @(posedge clk);
      #1;
      check("t4_elem1", bus.block_out[1*DW +: DW], 16'hffff);
      check("t4_elem2", bus.block_out[2*DW +: DW], 16'h0000);
      check("t4_elem5", bus.block_out[5*DW +: DW], 16'hffff);
      check("t4_elem7", bus.block_out[7*DW +: DW], 16'h0001);
      complete(0, 1'b0);

      // Zero pitch re-reads the same five words on every row.
      issue(1'b1, 16'h0010, 16'h0000, '0);
      repeat (26) @(posedge clk);
      #1;
      check("t7_elem5",  bus.block_out[5*DW +: DW], 16'h0010);
      check("t7_elem24", bus.block_out[24*DW +: DW], 16'h0014);
      complete(1, 1'b0);

      // Reset in the twelfth READ cycle.
      issue(1'b1, 16'h0200, 16'h0007, '0);
      repeat (11) @(posedge clk);
      #1;
      check("t5_en_before", bus.mem_enable, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_en_after",   bus.mem_enable, 0);
      check("t5_addr_after", bus.mem_address, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         cnt_a += int'(bus.block_valid);
         cnt_b += int'(bus.mem_enable);
      end
      check("t5_valid_never", cnt_a, 0);
      check("t5_no_strobes",  cnt_b, 0);
      salt = 16'h0f0f;
      issue(1'b1, 16'h0203, 16'h0011, '0);
      complete(2, 1'b1);

      // Back-to-back: handshake then start in the very next cycle.
      issue(1'b1, 16'h0300, 16'h0010, '0);
      repeat (26) @(posedge clk);
      #1;
      bus.block_ready = 1'b1;
      @(posedge clk); #1;
      bus.block_ready = 1'b0;
      check("t6_ready_after_hs", bus.cmd_ready, 1);
      for (int k = 0; k < BS; k++) blk[k*DW +: DW] = 16'($urandom);
      issue(1'b0, 16'h0400, 16'h0003, blk);
      check("t6_second_en", bus.mem_enable, 1);
      check("t6_second_rw", bus.mem_rw, 0);
      complete(0, 1'b1);

      // Randomized commands.
      for (int it = 0; it < 25; it++) begin
         logic [AW-1:0] b;
         logic [AW-1:0] p;
         salt = 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 16'hfff0 + 16'($urandom_range(0, 15)) : 16'($urandom);
         p = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         for (int k = 0; k < BS; k++) blk[k*DW +: DW] = 16'($urandom);
         issue(1'($urandom), b, p, blk);
         complete($urandom_range(0, 5), 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
